add_one_arbiter: RTL and testbench
==================================

Name: add_one_arbiter

Overview:
Shares a single add_one server between N_REQ find_max-style callers. Each caller has a request channel (x_out) and a response channel (return_in). Both use the codebase's busy/vld/data point-to-point handshake: a transfer occurs on a rising clk edge when vld=1 and busy=0. Requests are granted round-robin and forwarded in order. Up to DEPTH requests may be outstanding, and each server result is routed back to the caller that issued it, using an in-order tag FIFO.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 32, payload width
DEPTH, 4, maximum outstanding server transactions (tag FIFO depth, power of 2)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, synchronous, active-high
req_x_vld  in  N_REQ  per-requester request valid
req_x_data  in  N_REQ*DATA_W  per-requester request payload; requester i occupies bits [i*DATA_W +: DATA_W]
req_x_busy  out  N_REQ  per-requester request busy
req_ret_vld  out  N_REQ  per-requester response valid
req_ret_data  out  DATA_W  response payload, shared by all requesters; meaningful only where req_ret_vld=1
req_ret_busy  in  N_REQ  per-requester response busy
srv_x_vld  out  1  request valid to add_one
srv_x_data  out  DATA_W  request payload to add_one
srv_x_busy  in  1  add_one request busy
srv_ret_vld  in  1  add_one result valid
srv_ret_data  in  DATA_W  add_one result
srv_ret_busy  out  1  result busy toward add_one
outstanding  out  clog2(DEPTH)+1  number of tags currently in the FIFO

Behaviour:
- Reset (rst=1 at an edge):
  - srv_x_vld=0, req_ret_vld=0, hold register empty.
  - Round-robin pointer rr=0, tag FIFO empty, outstanding=0.
  - While rst=1: req_x_busy=all 1s and srv_ret_busy=1, regardless of other inputs.
  - Reset mid-transaction discards in-flight requests, held results and tags. Nothing is replayed.
- Issue path:
  - can_issue = (srv_x_vld==0 | srv_x_busy==0) & (outstanding<DEPTH).
  - When can_issue, grant goes to the first i with req_x_vld[i]=1, searching from rr upward with wrap.
  - req_x_busy[i] = ~(can_issue & grant==i). This is combinational; exactly one bit is low when any request is granted, and all bits are 1 otherwise.
  - On a granted transfer edge:
    - srv_x_data<=req_x_data[i] and srv_x_vld<=1;
    - push tag i into the FIFO;
    - rr<=(i+1) mod N_REQ.
  - Issue latency: one cycle; srv_x_vld is visible the cycle after acceptance.
  - If the server accepts (srv_x_busy=0) with no new grant, srv_x_vld<=0.
  - rr is unchanged on cycles with no grant.
  - srv_x_data is held stable while srv_x_vld=1 & srv_x_busy=1.
- Return path:
  - A single-entry hold register carries hold_data and hold_tag.
  - srv_ret_busy = tag FIFO empty | (hold_full & req_ret_busy[hold_tag]).
  - A result is never accepted with no outstanding tag.
  - On an accepted result edge: hold_data<=srv_ret_data, hold_tag<=FIFO head, pop the FIFO, hold_full<=1.
  - req_ret_vld = onehot(hold_tag) gated by hold_full. req_ret_data=hold_data.
  - The hold register clears when req_ret_busy[hold_tag]=0, unless a new result is loaded on the same edge.
  - Return latency: one cycle.
  - Back-to-back results at one per cycle when the caller is not busy.
- FIFO rules:
  - Push and pop on the same edge leave outstanding unchanged.
  - A push is blocked when outstanding==DEPTH; there is no same-cycle bypass on pop.
  - Pointers wrap mod DEPTH.
- The server must return results in request order; the block routes purely by FIFO order.
- Data passes through unmodified. There is no arithmetic on the payload.

Test Plan:
1. Single request: req_x_vld[0]=1 with data 0x0000_0007; server returns 0x0000_0008 the next cycle → srv_x_data=7 one cycle after acceptance; req_ret_vld=2'b01 with req_ret_data=8; outstanding goes 0→1→0.
2. Fairness: both requesters hold vld continuously with data 10+k and 20+k; server never busy → grants alternate 0,1,0,1; each requester receives its own values+1 in order.
3. Full FIFO: DEPTH=4; server holds srv_ret_vld=0 and accepts 4 requests → outstanding=4, req_x_busy=all 1s until the first result is popped; the fifth request issues the cycle after that pop.
4. Backpressure: srv_x_busy=1 for 3 cycles while srv_x_vld=1 → srv_x_data stays stable and no further grants occur; on release the transfer completes and rr advances only on grants.
5. Response stall: req_ret_busy[1]=1 while a result for tag 1 is held → srv_ret_busy=1 and the next server result (tag 0) waits; on release both are delivered on consecutive cycles.
6. Reset mid-flight: assert rst with 2 outstanding and a held result → the next cycle shows all valids 0, outstanding=0, srv_ret_busy=1; a fresh request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/add_one_arbiter.sv
// Round-robin arbiter sharing one add_one server between N_REQ callers.
// Results are routed back to their issuers through an in-order tag FIFO.
module add_one_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_x_vld,
  input  logic [N_REQ*DATA_W-1:0]   req_x_data,
  output logic [N_REQ-1:0]          req_x_busy,
  output logic [N_REQ-1:0]          req_ret_vld,
  output logic [DATA_W-1:0]         req_ret_data,
  input  logic [N_REQ-1:0]          req_ret_busy,
  output logic                      srv_x_vld,
  output logic [DATA_W-1:0]         srv_x_data,
  input  logic                      srv_x_busy,
  input  logic                      srv_ret_vld,
  input  logic [DATA_W-1:0]         srv_ret_data,
  output logic                      srv_ret_busy,
  output logic [$clog2(DEPTH):0]    outstanding
);

  localparam int unsigned TagW = $clog2(N_REQ);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic                srv_x_vld_q;
  logic [DATA_W-1:0]   srv_x_data_q;
  logic [TagW-1:0]     rr_q;
  logic [TagW-1:0]     tag_mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                hold_full_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [TagW-1:0]     hold_tag_q;

  logic                can_issue;
  logic                grant_vld;
  logic [TagW-1:0]     grant_idx;
  logic                ret_accept;
  logic                deliver;

  // The output slot is free if empty or being drained; the FIFO must have room.
  assign can_issue = ~rst & (~srv_x_vld_q | ~srv_x_busy) & (count_q < CntW'(DEPTH));

  always_comb begin : grant_search
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld && can_issue && req_x_vld[TagW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = TagW'(idx);
      end
    end
  end

  always_comb begin
    req_x_busy  = '1;
    req_ret_vld = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_x_busy[i]  = ~(grant_vld & (grant_idx == TagW'(i)));
      req_ret_vld[i] = hold_full_q & (hold_tag_q == TagW'(i));
    end
  end

  assign srv_ret_busy = rst | (count_q == '0) | (hold_full_q & req_ret_busy[hold_tag_q]);
  assign ret_accept   = srv_ret_vld & ~srv_ret_busy;
  assign deliver      = hold_full_q & ~req_ret_busy[hold_tag_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      srv_x_vld_q  <= 1'b0;
      srv_x_data_q <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_tag_q   <= '0;
    end else begin
      if (grant_vld) begin
        srv_x_vld_q          <= 1'b1;
        srv_x_data_q         <= req_x_data[grant_idx*DATA_W +: DATA_W];
        tag_mem_q[wr_ptr_q]  <= grant_idx;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
        rr_q                 <= (grant_idx == TagW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (!srv_x_busy) begin
        srv_x_vld_q <= 1'b0;
      end

      // A load on the same edge as a delivery keeps the slot full.
      if (ret_accept) begin
        hold_data_q <= srv_ret_data;
        hold_tag_q  <= tag_mem_q[rd_ptr_q];
        hold_full_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + 1'b1;
      end else if (deliver) begin
        hold_full_q <= 1'b0;
      end

      case ({grant_vld, ret_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign srv_x_vld    = srv_x_vld_q;
  assign srv_x_data   = srv_x_data_q;
  assign req_ret_data = hold_data_q;
  assign outstanding  = count_q;

endmodule

// File: tb/tb_add_one_arbiter.sv
// Randomized bench for add_one_arbiter: a transaction-level model with queues,
// an in-bench add_one server and per-caller response scoreboards.
module tb_add_one_arbiter;
  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         req_x_vld, req_x_busy, req_ret_vld, req_ret_busy;
  logic [N*W-1:0]       req_x_data;
  logic [W-1:0]         req_ret_data, srv_x_data, srv_ret_data;
  logic                 srv_x_vld, srv_x_busy, srv_ret_vld, srv_ret_busy;
  logic [$clog2(D):0]   outstanding;

  add_one_arbiter #(.N_REQ(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_x_vld(req_x_vld), .req_x_data(req_x_data), .req_x_busy(req_x_busy),
    .req_ret_vld(req_ret_vld), .req_ret_data(req_ret_data), .req_ret_busy(req_ret_busy),
    .srv_x_vld(srv_x_vld), .srv_x_data(srv_x_data), .srv_x_busy(srv_x_busy),
    .srv_ret_vld(srv_ret_vld), .srv_ret_data(srv_ret_data), .srv_ret_busy(srv_ret_busy),
    .outstanding(outstanding)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model: issue slot, tags in flight, the return hold slot, the server's queue.
  int          m_rr;
  int          m_tags[$];
  logic        m_sv;
  logic [W-1:0] m_sd;
  logic        m_hf;
  logic [W-1:0] m_hd;
  int          m_ht;
  logic [W-1:0] srvq[$];
  logic [W-1:0] exp_resp[N][$];

  int p_sxb, p_srv, p_rrb;
  logic [N-1:0] rrb_force;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_tags.delete();
    m_sv = 1'b0;
    m_sd = '0;
    m_hf = 1'b0;
    m_hd = '0;
    m_ht = 0;
    srvq.delete();
    for (int i = 0; i < N; i++) exp_resp[i].delete();
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    int g;
    logic can, esrb, acc;
    logic [N-1:0] eb;
    @(negedge clk);
    rst        = r;
    req_x_vld  = v;
    req_x_data = d;
    srv_x_busy = ($urandom_range(99) < p_sxb);
    for (int i = 0; i < N; i++)
      req_ret_busy[i] = ($urandom_range(99) < p_rrb) | rrb_force[i];
    srv_ret_vld  = (srvq.size() > 0) && ($urandom_range(99) < p_srv);
    srv_ret_data = (srvq.size() > 0) ? srvq[0] + 1 : $urandom;
    #1;
    g   = -1;
    can = !r && (!m_sv || !srv_x_busy) && (m_tags.size() < D);
    if (can)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
    eb = '1;
    if (g >= 0) eb[g] = 1'b0;
    esrb = r || (m_tags.size() == 0) || (m_hf && req_ret_busy[m_ht]);

    check("req_x_busy", req_x_busy, eb);
    check("srv_ret_busy", srv_ret_busy, esrb);
    check("srv_x_vld", srv_x_vld, m_sv);
    if (m_sv) check("srv_x_data", srv_x_data, m_sd);
    check("outstanding", outstanding, m_tags.size());
    check("req_ret_vld", req_ret_vld, m_hf ? (1 << m_ht) : 0);
    if (m_hf) check("req_ret_data", req_ret_data, m_hd);

    if (r) begin
      model_reset();
    end else begin
      if (m_hf && !req_ret_busy[m_ht]) begin
        if (exp_resp[m_ht].size() == 0) begin
          n_total++;
          $display("FAIL resp_unexpected: caller %0d got 0x%0h, expected nothing", m_ht,
                   req_ret_data);
        end else begin
          check("resp_order", req_ret_data, exp_resp[m_ht].pop_front());
        end
      end
      acc = srv_ret_vld && !esrb;
      if (m_sv && !srv_x_busy) srvq.push_back(m_sd);
      if (acc) begin
        m_hd = srv_ret_data;
        m_ht = m_tags.pop_front();
        m_hf = 1'b1;
        void'(srvq.pop_front());
      end else if (m_hf && !req_ret_busy[m_ht]) begin
        m_hf = 1'b0;
      end
      if (g >= 0) begin
        m_sd = d[g*W +: W];
        m_sv = 1'b1;
        m_tags.push_back(g);
        m_rr = (g + 1) % N;
        exp_resp[g].push_back(d[g*W +: W] + 1);
      end else if (!srv_x_busy) begin
        m_sv = 1'b0;
      end
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] x;
    for (int i = 0; i < N; i++) x[i*W +: W] = $urandom;
    return x;
  endfunction

  initial begin
    p_sxb = 0; p_srv = 100; p_rrb = 0; rrb_force = '0;
    rst = 1'b1; req_x_vld = '0; req_x_data = '0; req_ret_busy = '0;
    srv_x_busy = 1'b0; srv_ret_vld = 1'b0; srv_ret_data = '0;
    repeat (3) @(posedge clk);
    model_reset();

    // Single request from caller 0.
    step(1'b0, 2'b01, {32'd0, 32'd7});
    check("t1_grant", req_x_busy, 2'b10);
    step(1'b0, 2'b00, '0);
    check("t1_srv_x_data", srv_x_data, 7);
    check("t1_outstanding1", outstanding, 1);
    step(1'b0, 2'b00, '0);
    check("t1_srv_ret_data", srv_ret_data, 8);
    step(1'b0, 2'b00, '0);
    check("t1_ret_vld", req_ret_vld, 2'b01);
    check("t1_ret_data", req_ret_data, 8);
    check("t1_outstanding0", outstanding, 0);

    // Fairness: both callers hold valid.
    step(1'b1, 2'b00, '0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 2'b11, {32'(20 + k), 32'(10 + k)});
      check("t2_alternate", req_x_busy, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    repeat (6) step(1'b0, 2'b00, '0);

    // Full FIFO: server withholds results.
    step(1'b1, 2'b00, '0);
    p_srv = 0;
    repeat (5) step(1'b0, 2'b11, rand_data());
    check("t3_full", outstanding, 4);
    check("t3_all_busy", req_x_busy, 2'b11);
    p_srv = 100;
    step(1'b0, 2'b11, rand_data());
    check("t3_pop_cycle_busy", req_x_busy, 2'b11);
    check("t3_pop_cycle_ret", srv_ret_busy, 0);
    step(1'b0, 2'b11, rand_data());
    check("t3_fifth_grant", req_x_busy, 2'b10);
    repeat (10) step(1'b0, 2'b00, '0);

    // Server request backpressure.
    step(1'b1, 2'b00, '0);
    step(1'b0, 2'b01, {32'd0, 32'h55});
    p_sxb = 100;
    repeat (3) begin
      step(1'b0, 2'b11, rand_data());
      check("t4_stable", srv_x_data, 32'h55);
      check("t4_no_grant", req_x_busy, 2'b11);
    end
    p_sxb = 0;
    step(1'b0, 2'b11, {32'd66, 32'd77});
    check("t4_rr_next", req_x_busy, 2'b01);
    repeat (6) step(1'b0, 2'b00, '0);

    // Response stall on caller 1.
    step(1'b1, 2'b00, '0);
    step(1'b0, 2'b10, {32'd5, 32'd0});
    step(1'b0, 2'b01, {32'd0, 32'd9});
    step(1'b0, 2'b00, '0);
    rrb_force = 2'b10;
    repeat (2) begin
      step(1'b0, 2'b00, '0);
      check("t5_held", req_ret_vld, 2'b10);
      check("t5_srv_ret_busy", srv_ret_busy, 1);
    end
    rrb_force = '0;
    step(1'b0, 2'b00, '0);
    check("t5_deliver1", req_ret_data, 6);
    step(1'b0, 2'b00, '0);
    check("t5_deliver0_vld", req_ret_vld, 2'b01);
    check("t5_deliver0_data", req_ret_data, 10);

    // Reset mid-flight.
    step(1'b1, 2'b00, '0);
    p_srv = 0;
    repeat (3) step(1'b0, 2'b11, rand_data());
    p_srv = 100; rrb_force = 2'b11;
    step(1'b0, 2'b00, '0);
    step(1'b1, 2'b11, rand_data());
    check("t6_rst_busy", req_x_busy, 2'b11);
    check("t6_rst_srb", srv_ret_busy, 1);
    rrb_force = '0;
    step(1'b0, 2'b11, rand_data());
    check("t6_ret_vld", req_ret_vld, 0);
    check("t6_outstanding", outstanding, 0);
    check("t6_srv_x_vld", srv_x_vld, 0);
    check("t6_grant0", req_x_busy, 2'b10);

    // Randomized traffic with varying pressure.
    for (int seg = 0; seg < 15; seg++) begin
      p_sxb = $urandom_range(70);
      p_srv = $urandom_range(20, 100);
      p_rrb = $urandom_range(70);
      for (int c = 0; c < 200; c++)
        step($urandom_range(199) == 0, N'($urandom), rand_data());
    end
    p_sxb = 0; p_srv = 100; p_rrb = 0;
    repeat (20) step(1'b0, 2'b00, '0);
    for (int i = 0; i < N; i++) check("drain_empty", exp_resp[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
